// File: rtl/axis_burst_gen.sv
// AXI-Stream pulse-burst generator: emits packed DAC beats that form a rectangular
// pulse train, either continuously or as a counted single-shot burst.
module axis_burst_gen #(
  parameter int SAMPLE_WIDTH     = 16,
  parameter int SAMPLES_PER_BEAT = 4,
  parameter int CNT_WIDTH        = 32
) (
  input  logic                                     aclk,
  input  logic                                     areset,
  input  logic [CNT_WIDTH-1:0]                     cfg_period,
  input  logic [CNT_WIDTH-1:0]                     cfg_width,
  input  logic signed [SAMPLE_WIDTH-1:0]           cfg_amplitude,
  input  logic                                     cfg_single,
  input  logic [CNT_WIDTH-1:0]                     cfg_count,
  input  logic                                     start,
  input  logic                                     stop,
  output logic [SAMPLE_WIDTH*SAMPLES_PER_BEAT-1:0] m_axis_tdata,
  output logic                                     m_axis_tvalid,
  output logic                                     m_axis_tlast,
  input  logic                                     m_axis_tready,
  output logic                                     trigger_out,
  output logic                                     busy
);

  localparam int DATA_W = SAMPLE_WIDTH * SAMPLES_PER_BEAT;
  // Sample index b*SPB+k needs at most CNT_WIDTH+4 bits for SPB <= 16.
  localparam int IDX_W  = CNT_WIDTH + 5;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                         r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0]           r_period, r_width, r_count;
  logic signed [SAMPLE_WIDTH-1:0] r_amp;
  logic                           r_single;
  logic [CNT_WIDTH-1:0]           r_beat, r_burst;
  logic                           r_stop_pend;
  logic                           r_trig;

  logic              w_run, w_start, w_hs, w_last, w_burst_done, w_finish;
  logic [IDX_W-1:0]  w_base;
  logic [DATA_W-1:0] w_tdata;

  function automatic logic signed [SAMPLE_WIDTH-1:0] lane_val(
    input logic [IDX_W-1:0]            idx,
    input logic [IDX_W-1:0]            lim,
    input logic signed [SAMPLE_WIDTH-1:0] amp
  );
    return (idx < lim) ? amp : '0;
  endfunction

  assign w_run        = (r_state == S_RUN);
  assign w_start      = (r_state == S_IDLE) && start;
  assign w_hs         = w_run && m_axis_tready;
  assign w_last       = (r_beat == r_period - CNT_WIDTH'(1));
  assign w_burst_done = r_single && (r_burst == r_count - CNT_WIDTH'(1));
  // A stop arriving on the closing handshake itself also ends the burst here.
  assign w_finish     = w_hs && w_last && (w_burst_done || r_stop_pend || stop);
  assign w_base       = IDX_W'(r_beat) * IDX_W'(SAMPLES_PER_BEAT);

  always_ff @(posedge aclk) begin
    if (areset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start)    w_state_nxt = S_RUN;
      S_RUN:   if (w_finish) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_period    <= '0;
      r_width     <= '0;
      r_count     <= '0;
      r_amp       <= '0;
      r_single    <= 1'b0;
      r_beat      <= '0;
      r_burst     <= '0;
      r_stop_pend <= 1'b0;
      r_trig      <= 1'b0;
    end else begin
      r_trig <= w_hs && (r_beat == '0);
      if (w_start) begin
        r_period    <= (cfg_period == '0) ? CNT_WIDTH'(1) : cfg_period;
        r_count     <= (cfg_count == '0) ? CNT_WIDTH'(1) : cfg_count;
        r_width     <= cfg_width;
        r_amp       <= cfg_amplitude;
        r_single    <= cfg_single;
        r_beat      <= '0;
        r_burst     <= '0;
        r_stop_pend <= 1'b0;
      end else if (w_run) begin
        if (stop) r_stop_pend <= 1'b1;
        if (w_hs) begin
          if (w_last) begin
            r_beat  <= '0;
            r_burst <= r_burst + CNT_WIDTH'(1);
          end else begin
            r_beat  <= r_beat + CNT_WIDTH'(1);
          end
        end
        if (w_finish) r_stop_pend <= 1'b0;
      end
    end
  end

  // Lanes depend only on registered state, so they hold steady through stalls.
  always_comb begin
    w_tdata = '0;
    if (w_run) begin
      for (int k = 0; k < SAMPLES_PER_BEAT; k++) begin
        w_tdata[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] =
          lane_val(w_base + IDX_W'(k), IDX_W'(r_width), r_amp);
      end
    end
  end

  assign m_axis_tdata  = w_tdata;
  assign m_axis_tvalid = w_run;
  assign m_axis_tlast  = w_run && w_last;
  assign trigger_out   = r_trig;
  assign busy          = w_run;

endmodule

// File: doc/axis_burst_gen.md
AXIS_BURST_GEN -- requirements
Module: axis_burst_gen

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, default 16, bits per DAC sample.
REQ-002 SHALL have parameter SAMPLES_PER_BEAT, default 4, samples packed per AXI-Stream beat (1..16).
REQ-003 SHALL have parameter CNT_WIDTH, default 32, width of period/width/count config fields.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 SHALL have port aclk, input, 1, sole clock; all logic on rising edge.
REQ-006 SHALL have port areset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port cfg_period, input, CNT_WIDTH, pulse period in beats.
REQ-008 SHALL have port cfg_width, input, CNT_WIDTH, pulse high time in samples.
REQ-009 SHALL have port cfg_amplitude, input, SAMPLE_WIDTH, signed pulse level.
REQ-010 SHALL have port cfg_single, input, 1, 0 = continuous, 1 = single-shot burst.
REQ-011 SHALL have port cfg_count, input, CNT_WIDTH, periods per single-shot burst.
REQ-012 SHALL have ports start and stop, input, 1 each, single-cycle commands.
REQ-013 SHALL have port m_axis_tdata, output, SAMPLE_WIDTH*SAMPLES_PER_BEAT, lane 0 in LSBs = earliest sample.
REQ-014 SHALL have ports m_axis_tvalid and m_axis_tlast (output, 1) and m_axis_tready (input, 1).
REQ-015 SHALL have port trigger_out, output, 1, one-cycle marker at the start of each period.
REQ-016 SHALL have port busy, output, 1, high while in RUN.

Function
REQ-017 SHALL implement FSM with states IDLE and RUN; IDLE -> RUN on start; RUN -> IDLE on completion per REQ-024/025.
REQ-018 SHALL latch all cfg_* inputs on the cycle start is accepted in IDLE; cfg changes during RUN SHALL have no effect.
REQ-019 SHALL treat latched period 0 as 1 and latched count 0 as 1.
REQ-020 SHALL drive m_axis_tvalid = 1 exactly when in RUN; the first beat (beat index 0) SHALL be valid the cycle after start.
REQ-021 SHALL advance beat index, period counter and burst counter only on handshake (tvalid && tready); tdata/tlast SHALL be stable while tvalid && !tready.
REQ-022 Lane k of beat b SHALL equal cfg_amplitude if (b*SAMPLES_PER_BEAT + k) < cfg_width, else 0; comparison SHALL be unsigned and overflow-free (width >= period*SAMPLES_PER_BEAT gives all lanes high).
REQ-023 m_axis_tlast SHALL be 1 on the beat with index period-1; beat index SHALL wrap to 0 after its handshake.
REQ-024 In single-shot mode, after handshake of the tlast beat of period number count, FSM SHALL return to IDLE.
REQ-025 stop in RUN SHALL be registered; FSM SHALL finish the current period and return to IDLE after its tlast handshake; stop in IDLE SHALL be ignored.
REQ-026 start while in RUN SHALL be ignored; start and stop together in IDLE SHALL start the burst (stop ignored).
REQ-027 trigger_out SHALL pulse high for one cycle, registered, on the cycle after the handshake of each beat index 0.
REQ-028 busy SHALL be 1 in RUN, 0 in IDLE.

Reset
REQ-029 With areset high at a clock edge, the FSM SHALL go to IDLE and all counters, pending stop and latched config SHALL clear to 0.
REQ-030 During and after reset, m_axis_tvalid, m_axis_tlast, trigger_out, busy SHALL be 0 and m_axis_tdata SHALL be 0.
REQ-031 Reset mid-burst SHALL abort immediately with no further beats; the next start SHALL begin at beat 0.

Verification
REQ-032 SPB=4, period=4, width=6, amp=1000, continuous, tready=1: beats [1000,1000,1000,1000], [1000,1000,0,0], [0x4], [0x4] repeat; tlast on every 4th beat; trigger_out one cycle after each beat 0.
REQ-033 Same config with tready toggled randomly: tdata/tlast held during stalls; handshaked sequence identical to REQ-032.
REQ-034 Single-shot, count=2, period=3: exactly 6 handshaked beats, two tlast, busy falls after the 6th handshake, tvalid=0 afterwards.
REQ-035 Continuous, stop pulsed on beat 1 of period=4: beats 2 and 3 still sent, tlast on beat 3, then IDLE.
REQ-036 period=0, width=100, amp=-5: every beat is all -5 with tlast=1 and trigger_out following each beat.
REQ-037 areset asserted mid-period: next cycle tvalid=0, busy=0; subsequent start restarts at beat 0 with freshly latched config.
